// File: rtl/rs232_write_cmd_decoder.sv
// ---------------------------------------------------------------------------
// rs232_write_cmd_decoder
//
// Turns the byte stream from the RS232 UART receiver into one-byte write
// strobes for GPU_HW_Control_Regs and the GPU RAM write port.
//
// Packet layout:  SYNC0 SYNC1 CMD A2 A1 A0 LEN [payload]
//   addr = {A2[3:0], A1, A0}   (A2[7:4] ignored)
//   LEN  = 0 means 256 bytes
//   CMD 8'h01 WRITE : LEN payload bytes, written to addr, addr+1, ...
//   CMD 8'h02 FILL  : one payload byte, written LEN times to addr, addr+1, ...
//   any other CMD   : pkt_err pulse, back to IDLE
// Address arithmetic wraps modulo 2^20 silently.
//
// Optional build macro:
//   CMD_TIMEOUT_EN  - abort a partially received packet when no byte has
//                     arrived for TIMEOUT_CYC clocks (pkt_err pulse, IDLE).
//                     FILL never times out. Without the macro a partial
//                     packet waits forever.
//
// Parameters:
//   SYNC0        first sync byte of a packet header  (8'h55)
//   SYNC1        second sync byte of a packet header (8'hAA)
//   TIMEOUT_CYC  inter-byte timeout in clk cycles    (used with CMD_TIMEOUT_EN)
//
// Ports:
//   clk       in   1   system clock
//   reset     in   1   asynchronous, active-high reset
//   rx_data   in   8   received UART byte
//   rx_valid  in   1   1-cycle strobe, rx_data valid (never on consecutive cycles)
//   wr_addr   out  20  write address, held until the next write
//   wr_data   out  8   write data, held until the next write
//   wr_en     out  1   1-cycle write strobe
//   busy      out  1   high whenever the parser is not in IDLE
//   pkt_err   out  1   1-cycle pulse on bad command, overrun or timeout
//
// Handshake: rx_valid is a one-cycle strobe with no backpressure; every
// strobed byte is consumed in the cycle it is presented. wr_en is a
// one-cycle strobe qualifying wr_addr/wr_data in the same cycle; the
// consumer has no way to stall it.
// ---------------------------------------------------------------------------
module rs232_write_cmd_decoder #(
    parameter logic [7:0] SYNC0       = 8'h55,
    parameter logic [7:0] SYNC1       = 8'hAA,
    parameter int         TIMEOUT_CYC = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [19:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        wr_en,
    output logic        busy,
    output logic        pkt_err
);

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_FILL  = 8'h02;

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_SYNC = 4'd1;  // SYNC0 seen, expecting SYNC1
    localparam logic [3:0] S_CMD  = 4'd2;  // expecting command byte
    localparam logic [3:0] S_AH   = 4'd3;  // expecting A2
    localparam logic [3:0] S_AM   = 4'd4;  // expecting A1
    localparam logic [3:0] S_AL   = 4'd5;  // expecting A0
    localparam logic [3:0] S_LEN  = 4'd6;  // expecting LEN
    localparam logic [3:0] S_DATA = 4'd7;  // WRITE payload bytes
    localparam logic [3:0] S_FVAL = 4'd8;  // FILL payload byte
    localparam logic [3:0] S_FILL = 4'd9;  // FILL running, one write per clk

    // A zero timeout would abort every packet on the first idle cycle.
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    logic [3:0]  state;
    logic        cmd_fill;   // latched command: 1 = FILL, 0 = WRITE
    logic [19:0] addr_q;     // address of the next write
    logic [8:0]  remain;     // writes still to issue, 1..256 while active
    logic [7:0]  fill_val;
    logic        tmo_hit;

    assign busy = (state != S_IDLE);

`ifdef CMD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_active;

    // Counting covers every state that waits on the UART. FILL produces its
    // own writes, so it is excluded and can never time out.
    assign tmo_active = (state != S_IDLE) && (state != S_FILL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (!tmo_active || rx_valid || tmo_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Fires on the TIMEOUT_CYC-th idle clock after the last byte.
    assign tmo_hit = tmo_active && !rx_valid && (tmo_cnt == TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cmd_fill <= 1'b0;
            addr_q   <= '0;
            remain   <= '0;
            fill_val <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_en    <= 1'b0;
            pkt_err  <= 1'b0;
        end else begin
            wr_en   <= 1'b0;
            pkt_err <= 1'b0;

            if (tmo_hit) begin
                // Writes already issued stand; only the remainder is dropped.
                pkt_err <= 1'b1;
                state   <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (rx_valid && rx_data == SYNC0) begin
                            state <= S_SYNC;
                        end
                    end

                    S_SYNC: begin
                        if (rx_valid) begin
                            if (rx_data == SYNC1) begin
                                state <= S_CMD;
                            end else if (rx_data != SYNC0) begin
                                // Noise between packets, not an error.
                                state <= S_IDLE;
                            end
                        end
                    end

                    S_CMD: begin
                        if (rx_valid) begin
                            if (rx_data == CMD_WRITE || rx_data == CMD_FILL) begin
                                cmd_fill <= (rx_data == CMD_FILL);
                                state    <= S_AH;
                            end else begin
                                pkt_err <= 1'b1;
                                state   <= S_IDLE;
                            end
                        end
                    end

                    S_AH: begin
                        if (rx_valid) begin
                            addr_q[19:16] <= rx_data[3:0];
                            state         <= S_AM;
                        end
                    end

                    S_AM: begin
                        if (rx_valid) begin
                            addr_q[15:8] <= rx_data;
                            state        <= S_AL;
                        end
                    end

                    S_AL: begin
                        if (rx_valid) begin
                            addr_q[7:0] <= rx_data;
                            state       <= S_LEN;
                        end
                    end

                    S_LEN: begin
                        if (rx_valid) begin
                            // LEN 0 becomes 9'h100: the ninth bit is just (LEN == 0).
                            remain <= {(rx_data == 8'h00), rx_data};
                            state  <= cmd_fill ? S_FVAL : S_DATA;
                        end
                    end

                    S_DATA: begin
                        if (rx_valid) begin
                            wr_en   <= 1'b1;
                            wr_addr <= addr_q;
                            wr_data <= rx_data;
                            addr_q  <= addr_q + 20'd1;
                            remain  <= remain - 9'd1;
                            if (remain == 9'd1) begin
                                state <= S_IDLE;
                            end
                        end
                    end

                    S_FVAL: begin
                        // The first fill write goes out with the payload byte so
                        // that all LEN writes land on consecutive clocks.
                        if (rx_valid) begin
                            fill_val <= rx_data;
                            wr_en    <= 1'b1;
                            wr_addr  <= addr_q;
                            wr_data  <= rx_data;
                            addr_q   <= addr_q + 20'd1;
                            remain   <= remain - 9'd1;
                            state    <= (remain == 9'd1) ? S_IDLE : S_FILL;
                        end
                    end

                    S_FILL: begin
                        wr_en   <= 1'b1;
                        wr_addr <= addr_q;
                        wr_data <= fill_val;
                        addr_q  <= addr_q + 20'd1;
                        remain  <= remain - 9'd1;
                        if (remain == 9'd1) begin
                            state <= S_IDLE;
                        end
                        // A byte arriving mid-fill has nowhere to go.
                        if (rx_valid) begin
                            pkt_err <= 1'b1;
                        end
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
